fx2_tx_packetizer: RTL and testbench

FX2_TX_PACKETIZER -- requirements
Module: fx2_tx_packetizer

---
 rtl/fx2_tx_packetizer.sv | 198 +++++++++++++++++++
 tb/tb_fx2_tx_packetizer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx2_tx_packetizer.sv
// -----------------------------------------------------------------------------
// fx2_tx_packetizer
//   Collects user bytes in a small first-word-fall-through buffer and streams
//   them into the FX2 slave FIFO4. It commits packets in two ways:
//     - Full packets of MAX_PKT bytes commit automatically, with no PKTEND.
//     - Short packets commit with a single-cycle FIFO_PKTEND pulse. This
//       happens after IDLE_TIMEOUT empty-buffer cycles, or on a flush request.
//
// Ports
//   FX2_CLK                     : single clock, rising edge
//   FX2_RESETn                  : asynchronous active-low reset; release is
//                                 synchronised internally
//   in_data / in_valid          : user byte and its qualifier
//   in_ready                    : buffer not full
//   flush                       : one-cycle request to commit a short packet
//   FIFO4_ready_to_accept_data  : FX2 FIFO4 not full
//   FIFO_DATAOUT / _OE          : data bus to the FX2 and its output enable
//   FIFO_WR                     : write strobe into FIFO4
//   FIFO_PKTEND                 : short-packet commit strobe
//   pkt_count                   : committed packets (full and short), wraps
//   busy                        : FSM not idle, or bytes still buffered
// -----------------------------------------------------------------------------
module fx2_tx_packetizer #(
    parameter int MAX_PKT      = 512,
    parameter int IDLE_TIMEOUT = 64,
    parameter int DEPTH        = 16
) (
    input  logic        FX2_CLK,
    input  logic        FX2_RESETn,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    input  logic        FIFO4_ready_to_accept_data,
    output logic [7:0]  FIFO_DATAOUT,
    output logic        FIFO_DATAOUT_OE,
    output logic        FIFO_WR,
    output logic        FIFO_PKTEND,
    output logic [15:0] pkt_count,
    output logic        busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = AW + 1;
    localparam int BW = $clog2(MAX_PKT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_WRITE  = 3'd2,
        S_PKTEND = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    logic [1:0]    rst_sync_q;
    logic          rst_core_n;
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_s, count_next_s;
    logic          empty_s, full_s, push_s, wr_en_s, flush_pend_s;
    state_t        state_q, state_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]    idle_cnt_q, idle_cnt_d;
    logic          flush_q, flush_d;
    logic [15:0]   pkt_count_q, pkt_count_d;
    logic          oe_q, oe_d, pktend_q, pktend_d;

    // Reset synchroniser: asserts asynchronously, releases two edges later.
    always_ff @(posedge FX2_CLK or negedge FX2_RESETn) begin
        if (!FX2_RESETn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync_q[1];

    // Buffer occupancy from the wrap-bit pointers.
    assign count_s = wr_ptr_q - rd_ptr_q;
    assign empty_s = (count_s == '0);
    assign full_s  = (count_s == PW'(DEPTH));

    // A full buffer refuses a push even when a pop happens in the same cycle.
    assign push_s  = in_valid && !full_s;
    assign wr_en_s = (state_q == S_WRITE) && !empty_s && FIFO4_ready_to_accept_data;

    // Buffer storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge FX2_CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end

    // Next-state, counters and packet commit decisions.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + PW'(push_s);
        rd_ptr_d     = rd_ptr_q + PW'(wr_en_s);
        count_next_s = wr_ptr_d - rd_ptr_d;
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        flush_d      = flush_q;
        pkt_count_d  = pkt_count_q;
        // A flush counts only once the packet holds at least one byte.
        flush_pend_s = flush_q || (flush && (byte_cnt_q != '0));
        case (state_q)
            S_IDLE: begin
                if (!empty_s) begin
                    state_d = S_ARM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wr_en_s) begin
                    byte_cnt_d = byte_cnt_q + BW'(1);
                    idle_cnt_d = 8'd0;
                end else if (empty_s) begin
                    // Saturate so a long idle spell can never wrap the counter.
                    if (idle_cnt_q != 8'hFF) begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end else begin
                        idle_cnt_d = idle_cnt_q;
                    end
                end else begin
                    // Stalled on a full FIFO4: neither idle nor writing.
                    idle_cnt_d = idle_cnt_q;
                end
                flush_d = flush_pend_s;
                if (byte_cnt_d == BW'(MAX_PKT)) begin
                    state_d     = S_GAP;
                    pkt_count_d = pkt_count_q + 16'd1;
                // A pending flush fires on the cycle that drains the last byte.
                end else if ((byte_cnt_d != '0) &&
                             ((idle_cnt_q == 8'(IDLE_TIMEOUT)) ||
                              (flush_pend_s && (count_next_s == '0)))) begin
                    state_d = S_PKTEND;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_PKTEND: begin
                pkt_count_d = pkt_count_q + 16'd1;
                state_d     = S_GAP;
            end
            S_GAP: begin
                byte_cnt_d = '0;
                idle_cnt_d = 8'd0;
                flush_d    = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        oe_d     = (state_d == S_ARM) || (state_d == S_WRITE);
        pktend_d = (state_d == S_PKTEND);
    end

    // FSM, pointers, counters and registered bus controls.
    always_ff @(posedge FX2_CLK or negedge rst_core_n) begin
        if (!rst_core_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= 8'd0;
            flush_q     <= 1'b0;
            pkt_count_q <= 16'd0;
            oe_q        <= 1'b0;
            pktend_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            flush_q     <= flush_d;
            pkt_count_q <= pkt_count_d;
            oe_q        <= oe_d;
            pktend_q    <= pktend_d;
        end
    end

    // FIFO_WR stays combinational so it follows FIFO4's full flag in the same cycle.
    assign in_ready        = !full_s;
    assign FIFO_DATAOUT    = mem_q[rd_ptr_q[AW-1:0]];
    assign FIFO_DATAOUT_OE = oe_q;
    assign FIFO_WR         = wr_en_s;
    assign FIFO_PKTEND     = pktend_q;
    assign pkt_count       = pkt_count_q;
    assign busy            = (state_q != S_IDLE) || !empty_s;

endmodule

// File: tb/tb_fx2_tx_packetizer.sv
module tb_fx2_tx_packetizer;

    localparam int MAX_PKT      = 512;
    localparam int IDLE_TIMEOUT = 64;
    localparam int DEPTH        = 16;

    logic        FX2_CLK = 1'b0;
    logic        FX2_RESETn = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        FIFO4_ready_to_accept_data = 1'b0;
    logic [7:0]  FIFO_DATAOUT;
    logic        FIFO_DATAOUT_OE;
    logic        FIFO_WR;
    logic        FIFO_PKTEND;
    logic [15:0] pkt_count;
    logic        busy;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_wr = 0;
    int          n_pe = 0;
    int          pkt_bytes = 0;
    logic [15:0] exp_pkts = 16'h0000;
    logic [7:0]  exp_q[$];

    fx2_tx_packetizer #(
        .MAX_PKT(MAX_PKT),
        .IDLE_TIMEOUT(IDLE_TIMEOUT),
        .DEPTH(DEPTH)
    ) dut (
        .FX2_CLK(FX2_CLK),
        .FX2_RESETn(FX2_RESETn),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .FIFO4_ready_to_accept_data(FIFO4_ready_to_accept_data),
        .FIFO_DATAOUT(FIFO_DATAOUT),
        .FIFO_DATAOUT_OE(FIFO_DATAOUT_OE),
        .FIFO_WR(FIFO_WR),
        .FIFO_PKTEND(FIFO_PKTEND),
        .pkt_count(pkt_count),
        .busy(busy)
    );

    always #5 FX2_CLK = ~FX2_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge FX2_CLK);
        #1;
    endtask

    task automatic look();
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        look();
        for (int k = 0; k < 500; k++) begin
            if (in_ready) break;
            tick();
            look();
        end
        chk("push_ready", in_ready, 1);
        tick();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        look();
        for (int k = 0; k < budget; k++) begin
            if (!busy) break;
            tick();
            look();
        end
        chk(tag, busy, 0);
    endtask

    // Reference model: a queue of accepted bytes, a per-packet byte count and
    // the number of packets committed so far.
    always @(negedge FX2_CLK) begin
        if (!FX2_RESETn) begin
            exp_q.delete();
            pkt_bytes = 0;
            exp_pkts  = 16'h0000;
        end else begin
            chk("pkt_count", pkt_count, exp_pkts);
            chk("in_ready", in_ready, (exp_q.size() < DEPTH));
            if (FIFO_WR) begin
                n_wr++;
                chk("wr_oe", FIFO_DATAOUT_OE, 1);
                chk("wr_pe_excl", FIFO_PKTEND, 0);
                chk("wr_fifo4_ready", FIFO4_ready_to_accept_data, 1);
                chk("wr_nonempty", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("wr_data", FIFO_DATAOUT, exp_q.pop_front());
                end
                pkt_bytes++;
                if (pkt_bytes == MAX_PKT) begin
                    exp_pkts  = exp_pkts + 16'd1;
                    pkt_bytes = 0;
                end
            end
            if (FIFO_PKTEND) begin
                n_pe++;
                chk("pe_short", (pkt_bytes > 0 && pkt_bytes < MAX_PKT), 1);
                exp_pkts  = exp_pkts + 16'd1;
                pkt_bytes = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    initial begin
        int n;
        int wr0;
        int pe0;
        logic [15:0] pc0;

        // Reset values
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_wr", FIFO_WR, 0);
        chk("rst_pktend", FIFO_PKTEND, 0);
        chk("rst_oe", FIFO_DATAOUT_OE, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_count", pkt_count, 0);
        tick();
        tick();
        FX2_RESETn = 1'b1;
        tick();
        tick();
        tick();
        FIFO4_ready_to_accept_data = 1'b1;

        // Three bytes, ARM cycle, three writes, timeout commit
        in_valid = 1'b1;
        in_data  = 8'h11;
        tick();
        in_data  = 8'h22;
        tick();
        in_data  = 8'h33;
        look();
        chk("arm_oe", FIFO_DATAOUT_OE, 1);
        chk("arm_nowr", FIFO_WR, 0);
        tick();
        in_valid = 1'b0;
        look();
        chk("wr1", FIFO_WR, 1);
        chk("wr1_data", FIFO_DATAOUT, 8'h11);
        tick();
        look();
        chk("wr2_data", FIFO_DATAOUT, 8'h22);
        tick();
        look();
        chk("wr3", FIFO_WR, 1);
        chk("wr3_data", FIFO_DATAOUT, 8'h33);
        tick();
        look();
        chk("wr_after3", FIFO_WR, 0);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (FIFO_PKTEND) break;
            n++;
            tick();
            look();
        end
        chk("timeout_pktend", FIFO_PKTEND, 1);
        chk("timeout_len", (n >= IDLE_TIMEOUT && n <= IDLE_TIMEOUT + 2), 1);
        tick();
        look();
        chk("pktend_one_cycle", FIFO_PKTEND, 0);
        wait_idle("t1_idle", 20);
        chk("t1_pkt_count", pkt_count, 16'd1);

        // Full packet of MAX_PKT bytes commits without PKTEND
        wr0 = n_wr;
        pe0 = n_pe;
        pc0 = pkt_count;
        for (int i = 0; i < MAX_PKT; i++) push_byte(8'($urandom));
        in_valid = 1'b0;
        wait_idle("full_idle", 300);
        chk("full_writes", n_wr - wr0, MAX_PKT);
        chk("full_no_pktend", n_pe - pe0, 0);
        chk("full_pkt_count", pkt_count, pc0 + 16'd1);
        push_byte(8'hA5);
        in_valid = 1'b0;
        look();
        for (int k = 0; k < 10; k++) begin
            if (FIFO_DATAOUT_OE) break;
            tick();
            look();
        end
        chk("b513_arm_oe", FIFO_DATAOUT_OE, 1);
        chk("b513_arm_nowr", FIFO_WR, 0);
        tick();
        look();
        chk("b513_wr", FIFO_WR, 1);
        wait_idle("b513_idle", 200);
        chk("b513_pkt_count", pkt_count, pc0 + 16'd2);

        // Fill the buffer with FIFO4 full for 100 cycles
        FIFO4_ready_to_accept_data = 1'b0;
        wr0 = n_wr;
        pe0 = n_pe;
        for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h40 + i));
        in_data = 8'hEE;
        look();
        chk("full_in_ready", in_ready, 0);
        for (int k = 0; k < 100; k++) tick();
        look();
        chk("stall_no_wr", n_wr - wr0, 0);
        chk("stall_no_pe", n_pe - pe0, 0);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_busy", busy, 1);
        FIFO4_ready_to_accept_data = 1'b1;
        look();
        chk("full_pop_refuse", in_ready, 0);
        chk("full_pop_wr", FIFO_WR, 1);
        tick();
        in_valid = 1'b0;
        wait_idle("stall_idle", 300);
        chk("stall_writes", n_wr - wr0, DEPTH);
        chk("stall_one_pe", n_pe - pe0, 1);

        // Flush with two bytes still buffered
        FIFO4_ready_to_accept_data = 1'b0;
        pc0 = pkt_count;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h70 + i));
        in_valid = 1'b0;
        look();
        chk("fl_oe", FIFO_DATAOUT_OE, 1);
        FIFO4_ready_to_accept_data = 1'b1;
        tick();
        tick();
        tick();
        FIFO4_ready_to_accept_data = 1'b0;
        flush = 1'b1;
        look();
        chk("fl_stall", FIFO_WR, 0);
        tick();
        flush = 1'b0;
        FIFO4_ready_to_accept_data = 1'b1;
        look();
        chk("fl_wr4", FIFO_WR, 1);
        chk("fl_wr4_data", FIFO_DATAOUT, 8'h73);
        tick();
        look();
        chk("fl_wr5", FIFO_WR, 1);
        chk("fl_wr5_data", FIFO_DATAOUT, 8'h74);
        tick();
        look();
        chk("fl_pktend", FIFO_PKTEND, 1);
        chk("fl_pktend_nowr", FIFO_WR, 0);
        tick();
        look();
        chk("fl_pktend_off", FIFO_PKTEND, 0);
        wait_idle("fl_idle", 20);
        chk("fl_pkt_count", pkt_count, pc0 + 16'd1);

        // Flush while idle does nothing
        pe0 = n_pe;
        pc0 = pkt_count;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        look();
        chk("idle_flush_pe", n_pe - pe0, 0);
        chk("idle_flush_pc", pkt_count, pc0);
        chk("idle_flush_oe", FIFO_DATAOUT_OE, 0);

        // Reset mid-packet after three of ten bytes written
        FIFO4_ready_to_accept_data = 1'b0;
        for (int i = 0; i < 10; i++) push_byte(8'(8'h90 + i));
        in_valid = 1'b0;
        wr0 = n_wr;
        pe0 = n_pe;
        FIFO4_ready_to_accept_data = 1'b1;
        tick();
        tick();
        tick();
        #2;
        chk("mid_writes", n_wr - wr0, 3);
        FX2_RESETn = 1'b0;
        #1;
        chk("arst_wr", FIFO_WR, 0);
        chk("arst_pktend", FIFO_PKTEND, 0);
        chk("arst_oe", FIFO_DATAOUT_OE, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_pkt_count", pkt_count, 16'd0);
        tick();
        tick();
        FX2_RESETn = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        look();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_no_pe", n_pe - pe0, 0);
        chk("post_rst_pkt_count", pkt_count, 16'd0);

        // pkt_count wraps from 0xFFFF
        tick();
        look();
        force dut.pkt_count_q = 16'hFFFF;
        exp_pkts = 16'hFFFF;
        tick();
        release dut.pkt_count_q;
        look();
        chk("preload_ffff", pkt_count, 16'hFFFF);
        push_byte(8'h5A);
        in_valid = 1'b0;
        wait_idle("wrap_idle", 200);
        chk("wrap_zero", pkt_count, 16'h0000);

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            FIFO4_ready_to_accept_data = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 19) == 0);
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        FIFO4_ready_to_accept_data = 1'b1;
        wait_idle("rand_drain", 400);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
